// File: rtl/vic20_clk_sequencer.sv
// Post-PLL clock sequencer: synchronises PLL lock, sequences the core reset and
// produces phase-aligned pixel / PHI2 clock enables from the master clock.
module vic20_clk_sequencer #(
   parameter int DIV_CPU    = 32,
   parameter int DIV_PIX    = 8,
   parameter int LOCK_HOLD  = 1024,
   parameter int RST_CYCLES = 16
) (
   input  logic                       clk_sys,
   input  logic                       reset,
   input  logic                       pll_locked,
   input  logic                       pause,
   output logic                       ce_pix,
   output logic                       ce_cpu_p,
   output logic                       ce_cpu_n,
   output logic [$clog2(DIV_CPU)-1:0] phase,
   output logic                       core_reset,
   output logic                       running
);

   localparam int PH_W  = $clog2(DIV_CPU);
   localparam int CNT_W = $clog2(LOCK_HOLD + RST_CYCLES + 1);

   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(DIV_CPU - 1);
   localparam logic [PH_W-1:0]  PH_HALF   = PH_W'(DIV_CPU / 2);
   localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(LOCK_HOLD - 1);
   localparam logic [CNT_W-1:0] RST_END    = CNT_W'(RST_CYCLES);

   typedef enum logic [1:0] {
      WAIT_LOCK  = 2'd0,
      SETTLE     = 2'd1,
      RESET_HOLD = 2'd2,
      RUN        = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic              s1_q, s1_d;
   logic              locked_s_q, locked_s_d;
   logic              pause_l_q, pause_l_d;
   logic              ce_pix_q, ce_pix_d;
   logic              ce_cpu_p_q, ce_cpu_p_d;
   logic              ce_cpu_n_q, ce_cpu_n_d;
   logic              core_reset_q, core_reset_d;
   logic              running_q, running_d;

   logic              last_ph;
   logic [PH_W-1:0]   phase_inc;
   logic              active;

   always_comb begin
      s1_d       = pll_locked;
      locked_s_d = s1_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      phase_d    = phase_q;
      pause_l_d  = pause_l_q;

      last_ph   = (phase_q == PH_LAST);
      phase_inc = last_ph ? '0 : phase_q + PH_W'(1);

      case (state_q)
         WAIT_LOCK: begin
            phase_d = '0;
            cnt_d   = '0;
            if (locked_s_q) state_d = SETTLE;
         end
         SETTLE: begin
            phase_d = '0;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == SETTLE_END) begin
               state_d = RESET_HOLD;
               cnt_d   = '0;
            end
         end
         RESET_HOLD: begin
            phase_d = phase_inc;
            // Every phase-0 cycle here carries a ce_cpu_p, since pause is masked
            if (phase_q == '0) cnt_d = cnt_q + CNT_W'(1);
            if (last_ph && (cnt_q == RST_END)) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            phase_d = phase_inc;
         end
         default: begin
            state_d = WAIT_LOCK;
            phase_d = '0;
            cnt_d   = '0;
         end
      endcase

      // Losing lock overrides every other transition
      if ((state_q != WAIT_LOCK) && !locked_s_q) begin
         state_d = WAIT_LOCK;
         phase_d = '0;
         cnt_d   = '0;
      end

      // Pause is latched only at the CPU cycle boundary so a cycle runs or stalls whole
      if (state_d == RUN) begin
         if (last_ph) pause_l_d = pause;
      end else begin
         pause_l_d = 1'b0;
      end

      active       = (state_d == RESET_HOLD) || (state_d == RUN);
      ce_pix_d     = active && ((32'(phase_d) % DIV_PIX) == 0);
      ce_cpu_p_d   = active && (phase_d == '0) && !pause_l_d;
      ce_cpu_n_d   = active && (phase_d == PH_HALF) && !pause_l_d;
      core_reset_d = (state_d != RUN);
      running_d    = (state_d == RUN);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         s1_q         <= 1'b0;
         locked_s_q   <= 1'b0;
         state_q      <= WAIT_LOCK;
         cnt_q        <= '0;
         phase_q      <= '0;
         pause_l_q    <= 1'b0;
         ce_pix_q     <= 1'b0;
         ce_cpu_p_q   <= 1'b0;
         ce_cpu_n_q   <= 1'b0;
         core_reset_q <= 1'b1;
         running_q    <= 1'b0;
      end else begin
         s1_q         <= s1_d;
         locked_s_q   <= locked_s_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         phase_q      <= phase_d;
         pause_l_q    <= pause_l_d;
         ce_pix_q     <= ce_pix_d;
         ce_cpu_p_q   <= ce_cpu_p_d;
         ce_cpu_n_q   <= ce_cpu_n_d;
         core_reset_q <= core_reset_d;
         running_q    <= running_d;
      end
   end

   assign ce_pix     = ce_pix_q;
   assign ce_cpu_p   = ce_cpu_p_q;
   assign ce_cpu_n   = ce_cpu_n_q;
   assign phase      = phase_q;
   assign core_reset = core_reset_q;
   assign running    = running_q;

endmodule

// File: tb/tb_vic20_clk_sequencer.sv
// Directed bench for vic20_clk_sequencer with small sequencing parameters.
module tb_vic20_clk_sequencer;

   logic       clk_sys;
   logic       reset;
   logic       pll_locked;
   logic       pause;
   logic       ce_pix;
   logic       ce_cpu_p;
   logic       ce_cpu_n;
   logic [4:0] phase;
   logic       core_reset;
   logic       running;

   int checks = 0;
   int errors = 0;
   int e      = 0;

   vic20_clk_sequencer #(
      .DIV_CPU   (32),
      .DIV_PIX   (8),
      .LOCK_HOLD (8),
      .RST_CYCLES(2)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .pll_locked(pll_locked),
      .pause     (pause),
      .ce_pix    (ce_pix),
      .ce_cpu_p  (ce_cpu_p),
      .ce_cpu_n  (ce_cpu_n),
      .phase     (phase),
      .core_reset(core_reset),
      .running   (running)
   );

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
      e++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".core_reset"}, 32'(core_reset), 32'd1);
      chk({tag, ".running"},    32'(running),    32'd0);
      chk({tag, ".phase"},      32'(phase),      32'd0);
      chk({tag, ".ce_pix"},     32'(ce_pix),     32'd0);
      chk({tag, ".ce_cpu_p"},   32'(ce_cpu_p),   32'd0);
      chk({tag, ".ce_cpu_n"},   32'(ce_cpu_n),   32'd0);
   endtask

   initial begin
      int n_pix, n_p, n_n, n_both, n_bad;

      // 1: power-up with lock present from the start
      reset      = 1'b1;
      pll_locked = 1'b1;
      pause      = 1'b0;
      step();
      reset = 1'b0;
      e     = 0;
      chk_reset_vals("t1_reset");
      for (int i = 1; i <= 74; i++) begin
         step();
         chk("t1_core_reset_held", 32'(core_reset), 32'd1);
         chk("t1_not_running", 32'(running), 32'd0);
         if (e == 10) chk("t1_pix_before_hold", 32'(ce_pix), 32'd0);
         if (e == 11) begin
            chk("t1_hold_phase", 32'(phase), 32'd0);
            chk("t1_hold_cpu_p", 32'(ce_cpu_p), 32'd1);
            chk("t1_hold_pix", 32'(ce_pix), 32'd1);
         end
         if (e == 27) chk("t1_hold_cpu_n", 32'(ce_cpu_n), 32'd1);
      end
      step();
      chk("t1_run_running", 32'(running), 32'd1);
      chk("t1_run_core_reset", 32'(core_reset), 32'd0);
      chk("t1_run_phase", 32'(phase), 32'd0);
      chk("t1_run_cpu_p", 32'(ce_cpu_p), 32'd1);

      // 2: enable cadence over 256 RUN cycles
      n_pix = 0; n_p = 0; n_n = 0; n_both = 0; n_bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (ce_pix) n_pix++;
         if (ce_pix !== ((phase % 8) == 0)) n_bad++;
         if (ce_cpu_p) begin n_p++; if (phase != 5'd0) n_bad++; end
         if (ce_cpu_n) begin n_n++; if (phase != 5'd16) n_bad++; end
         if (ce_cpu_p && ce_cpu_n) n_both++;
         step();
      end
      chk("t2_pix_count", 32'(n_pix), 32'd32);
      chk("t2_cpu_p_count", 32'(n_p), 32'd8);
      chk("t2_cpu_n_count", 32'(n_n), 32'd8);
      chk("t2_both_high", 32'(n_both), 32'd0);
      chk("t2_misaligned", 32'(n_bad), 32'd0);

      // 3: pause raised at phase 5 for 40 cycles
      for (int i = 0; i < 5; i++) step();
      chk("t3_start_phase", 32'(phase), 32'd5);
      pause = 1'b1;
      n_pix = 0; n_p = 0; n_n = 0; n_bad = 0;
      for (int i = 1; i <= 96; i++) begin
         step();
         if (ce_pix) n_pix++;
         if (ce_pix !== ((phase % 8) == 0)) n_bad++;
         if (ce_cpu_p) n_p++;
         if (ce_cpu_n) n_n++;
         if (i == 11) chk("t3_n_before_pause", 32'(ce_cpu_n), 32'd1);
         if (i == 27) begin
            chk("t3_paused_cpu_p", 32'(ce_cpu_p), 32'd0);
            chk("t3_paused_pix", 32'(ce_pix), 32'd1);
         end
         if (i == 43) chk("t3_paused_cpu_n", 32'(ce_cpu_n), 32'd0);
         if (i == 59) chk("t3_resume_cpu_p", 32'(ce_cpu_p), 32'd1);
         if (i == 40) pause = 1'b0;
      end
      chk("t3_cpu_p_count", 32'(n_p), 32'd2);
      chk("t3_cpu_n_count", 32'(n_n), 32'd2);
      chk("t3_pix_count", 32'(n_pix), 32'd12);
      chk("t3_pix_misaligned", 32'(n_bad), 32'd0);

      // 5: lock lost in RUN at phase 20, then relock
      for (int i = 0; i < 15; i++) step();
      chk("t5_start_phase", 32'(phase), 32'd20);
      pll_locked = 1'b0;
      step();
      chk("t5_e1_running", 32'(running), 32'd1);
      chk("t5_e1_phase", 32'(phase), 32'd21);
      step();
      chk("t5_e2_running", 32'(running), 32'd1);
      chk("t5_e2_phase", 32'(phase), 32'd22);
      step();
      chk_reset_vals("t5_lost");
      for (int i = 0; i < 5; i++) step();
      chk_reset_vals("t5_unlocked");
      pll_locked = 1'b1;
      e = 0;
      for (int i = 1; i <= 74; i++) begin
         step();
         chk("t5_relock_not_running", 32'(running), 32'd0);
         if (e == 10) chk("t5_relock_pix_settle", 32'(ce_pix), 32'd0);
         if (e == 11) begin
            chk("t5_relock_hold_cpu_p", 32'(ce_cpu_p), 32'd1);
            chk("t5_relock_hold_phase", 32'(phase), 32'd0);
         end
      end
      step();
      chk("t5_relock_running", 32'(running), 32'd1);
      chk("t5_relock_phase", 32'(phase), 32'd0);

      // 6: one-cycle reset in RUN, with pause high across it
      for (int i = 0; i < 3; i++) step();
      reset = 1'b1;
      pause = 1'b1;
      step();
      reset = 1'b0;
      pause = 1'b0;
      e     = 0;
      chk_reset_vals("t6_reset");
      for (int i = 1; i <= 74; i++) begin
         step();
         chk("t6_not_running", 32'(running), 32'd0);
      end
      step();
      chk("t6_running", 32'(running), 32'd1);
      chk("t6_core_reset", 32'(core_reset), 32'd0);
      chk("t6_phase", 32'(phase), 32'd0);

      // 4: 3-cycle lock glitch at settle count 5; pause ignored during the reset hold
      reset = 1'b1;
      step();
      reset = 1'b0;
      e     = 0;
      for (int i = 1; i <= 86; i++) begin
         step();
         if (e == 8)  pll_locked = 1'b0;
         if (e == 11) begin
            chk("t4_no_early_hold", 32'(ce_pix), 32'd0);
            pll_locked = 1'b1;
         end
         if (e == 21) begin
            chk("t4_e21_pix", 32'(ce_pix), 32'd0);
            chk("t4_e21_core_reset", 32'(core_reset), 32'd1);
            pause = 1'b1;
         end
         if (e == 22) begin
            chk("t4_hold_cpu_p", 32'(ce_cpu_p), 32'd1);
            chk("t4_hold_pix", 32'(ce_pix), 32'd1);
            chk("t4_hold_phase", 32'(phase), 32'd0);
         end
         if (e == 38) chk("t4_hold_cpu_n", 32'(ce_cpu_n), 32'd1);
         if (e == 54) begin
            chk("t4_hold_cpu_p2", 32'(ce_cpu_p), 32'd1);
            pause = 1'b0;
         end
         if (e == 85) chk("t4_not_yet_running", 32'(running), 32'd0);
      end
      chk("t4_running", 32'(running), 32'd1);
      chk("t4_run_phase", 32'(phase), 32'd0);
      chk("t4_run_cpu_p", 32'(ce_cpu_p), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
